// File: rtl/system.sv
// UART-to-GPIO bridge: input-nibble changes are reported as {4'hA, nibble} TX frames;
// received bytes drive the low nibble onto the upper GPIO pins.
module system #(
   parameter int clk_freq       = 50000000,
   parameter int uart_baud_rate = 115200
) (
   input  logic       clk,
   input  logic       rst,
   output logic       led,
   input  logic       uart_rxd,
   output logic       uart_txd,
   inout  wire  [7:0] gpio_io
);
   localparam int DIV  = clk_freq / uart_baud_rate;
   localparam int HALF = DIV / 2;
   localparam int CW   = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_DONE, RX_WAIT} rx_state_t;

   logic [3:0] in_meta_reg, in_sync_reg, last_in_reg;
   logic       in_event;
   logic       pending_reg, pending_next;

   tx_state_t     tx_state_reg, tx_state_next;
   logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
   logic [2:0]    tx_bit_reg, tx_bit_next;
   logic [7:0]    tx_shift_reg, tx_shift_next;
   logic          txd_reg, txd_next;
   logic          led_reg, led_next;
   logic          tx_load;

   logic          rx_meta_reg, rx_sync_reg, rx_prev_reg;
   rx_state_t     rx_state_reg, rx_state_next;
   logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
   logic [2:0]    rx_bit_reg, rx_bit_next;
   logic [7:0]    rx_shift_reg, rx_shift_next;
   logic [3:0]    gpio_out_reg, gpio_out_next;

   assign gpio_io[3:0] = 4'bzzzz;
   assign gpio_io[7:4] = gpio_out_reg;
   assign uart_txd     = txd_reg;
   assign led          = led_reg;

   // last_in follows in_sync every clock, so a mismatch lasts exactly one cycle per change
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_meta_reg <= 4'h0;
         in_sync_reg <= 4'h0;
         last_in_reg <= 4'h0;
         pending_reg <= 1'b0;
         rx_meta_reg <= 1'b0;
         rx_sync_reg <= 1'b0;
         rx_prev_reg <= 1'b0;
      end else begin
         in_meta_reg <= gpio_io[3:0];
         in_sync_reg <= in_meta_reg;
         last_in_reg <= in_sync_reg;
         pending_reg <= pending_next;
         rx_meta_reg <= uart_rxd;
         rx_sync_reg <= rx_meta_reg;
         rx_prev_reg <= rx_sync_reg;
      end
   end

   assign in_event     = (in_sync_reg != last_in_reg);
   assign pending_next = (pending_reg && !tx_load) || in_event;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_state_reg <= TX_IDLE;
         tx_cnt_reg   <= '0;
         tx_bit_reg   <= 3'd0;
         tx_shift_reg <= 8'h00;
         txd_reg      <= 1'b1;
         led_reg      <= 1'b0;
      end else begin
         tx_state_reg <= tx_state_next;
         tx_cnt_reg   <= tx_cnt_next;
         tx_bit_reg   <= tx_bit_next;
         tx_shift_reg <= tx_shift_next;
         txd_reg      <= txd_next;
         led_reg      <= led_next;
      end
   end

   // The shift register is consumed from bit 0; txd is registered one bit ahead of the shift
   always_comb begin
      tx_state_next = tx_state_reg;
      tx_cnt_next   = tx_cnt_reg;
      tx_bit_next   = tx_bit_reg;
      tx_shift_next = tx_shift_reg;
      txd_next      = txd_reg;
      tx_load       = 1'b0;
      case (tx_state_reg)
         TX_IDLE: begin
            txd_next = 1'b1;
            if (pending_reg) begin
               tx_load       = 1'b1;
               tx_shift_next = {4'hA, in_sync_reg};
               tx_cnt_next   = '0;
               txd_next      = 1'b0;
               tx_state_next = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_reg == DIV_LAST) begin
               tx_cnt_next   = '0;
               tx_bit_next   = 3'd0;
               txd_next      = tx_shift_reg[0];
               tx_shift_next = {1'b1, tx_shift_reg[7:1]};
               tx_state_next = TX_DATA;
            end else begin
               tx_cnt_next = tx_cnt_reg + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_reg == DIV_LAST) begin
               tx_cnt_next = '0;
               if (tx_bit_reg == 3'd7) begin
                  txd_next      = 1'b1;
                  tx_state_next = TX_STOP;
               end else begin
                  tx_bit_next   = tx_bit_reg + 1'b1;
                  txd_next      = tx_shift_reg[0];
                  tx_shift_next = {1'b1, tx_shift_reg[7:1]};
               end
            end else begin
               tx_cnt_next = tx_cnt_reg + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_reg == DIV_LAST) begin
               tx_cnt_next   = '0;
               tx_state_next = TX_IDLE;
            end else begin
               tx_cnt_next = tx_cnt_reg + 1'b1;
            end
         end
         default: tx_state_next = TX_IDLE;
      endcase
      led_next = (tx_state_next != TX_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_state_reg <= RX_IDLE;
         rx_cnt_reg   <= '0;
         rx_bit_reg   <= 3'd0;
         rx_shift_reg <= 8'h00;
         gpio_out_reg <= 4'h0;
      end else begin
         rx_state_reg <= rx_state_next;
         rx_cnt_reg   <= rx_cnt_next;
         rx_bit_reg   <= rx_bit_next;
         rx_shift_reg <= rx_shift_next;
         gpio_out_reg <= gpio_out_next;
      end
   end

   // After a framing error the receiver parks in RX_WAIT so a held-low line cannot retrigger it
   always_comb begin
      rx_state_next = rx_state_reg;
      rx_cnt_next   = rx_cnt_reg;
      rx_bit_next   = rx_bit_reg;
      rx_shift_next = rx_shift_reg;
      gpio_out_next = gpio_out_reg;
      case (rx_state_reg)
         RX_IDLE: begin
            rx_cnt_next = '0;
            if (rx_prev_reg && !rx_sync_reg) rx_state_next = RX_START;
         end
         RX_START: begin
            if (rx_cnt_reg == HALF_LAST) begin
               rx_cnt_next   = '0;
               rx_bit_next   = 3'd0;
               rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         RX_DATA: begin
            if (rx_cnt_reg == DIV_LAST) begin
               rx_cnt_next   = '0;
               rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
               if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
               else                    rx_bit_next   = rx_bit_reg + 1'b1;
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         RX_STOP: begin
            if (rx_cnt_reg == DIV_LAST) begin
               rx_cnt_next   = '0;
               rx_state_next = rx_sync_reg ? RX_DONE : RX_WAIT;
            end else begin
               rx_cnt_next = rx_cnt_reg + 1'b1;
            end
         end
         RX_DONE: begin
            gpio_out_next = rx_shift_reg[3:0];
            rx_state_next = RX_IDLE;
         end
         RX_WAIT: begin
            if (rx_sync_reg) rx_state_next = RX_IDLE;
         end
         default: rx_state_next = RX_IDLE;
      endcase
   end
endmodule

// File: tb/tb_system.sv
// Randomized scoreboard bench: stimulus pushes expected TX bytes / GPIO nibbles,
// independent monitors decode uart_txd and sample gpio_io[7:4] and compare.
module tb_system;
   localparam int CLK_FREQ = 50000000;
   localparam int BAUD     = 1152000;
   localparam int DIV      = CLK_FREQ / BAUD;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       uart_rxd = 1'b1;
   logic [3:0] in_nib   = 4'h0;
   wire  [7:0] gpio_io;
   wire        led;
   wire        uart_txd;

   assign gpio_io[3:0] = in_nib;

   system #(.clk_freq(CLK_FREQ), .uart_baud_rate(BAUD)) dut (
      .clk(clk), .rst(rst), .led(led), .uart_rxd(uart_rxd),
      .uart_txd(uart_txd), .gpio_io(gpio_io)
   );

   always #10 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   byte unsigned tx_exp[$];
   logic [3:0]  rx_exp[$];
   bit          skip_next = 1'b0;
   logic [3:0]  model_nib = 4'h0;
   logic [3:0]  rx_model  = 4'h0;
   logic [3:0]  pv[4];
   int          pg[4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the first real change in a burst is sent as-is; any later changes inside the
   // same frame coalesce into one more frame carrying the final value.
   task automatic tx_phase(input int n);
      int         events = 0;
      logic [3:0] cur;
      cur = model_nib;
      for (int i = 0; i < n; i++) begin
         repeat (pg[i]) @(negedge clk);
         in_nib = pv[i];
         if (pv[i] != cur) begin
            events++;
            if (events == 1) tx_exp.push_back({4'hA, pv[i]});
            cur = pv[i];
         end
      end
      if (events > 1) tx_exp.push_back({4'hA, cur});
      model_nib = cur;
      if (events == 0) begin
         repeat (10) @(negedge clk);
         check("led_nochange", {31'd0, led}, 32'd0);
      end
      repeat (1000) @(negedge clk);
      check("led_quiet", {31'd0, led}, 32'd0);
      check("txd_quiet", {31'd0, uart_txd}, 32'd1);
      $display("tx phase: %0d writes, %0d events, nibble %h", n, events, cur);
   endtask

   task automatic tx_seq();
      pv[0] = 4'hA; pg[0] = 20;
      tx_phase(1);
      pv[0] = 4'hA; pg[0] = 20;
      tx_phase(1);
      pv[0] = 4'h5; pv[1] = 4'h0; pv[2] = 4'hA;
      pg[0] = 20;   pg[1] = 100;  pg[2] = 150;
      tx_phase(3);
      for (int p = 0; p < 10; p++) begin
         int n;
         n = $urandom_range(1, 4);
         for (int i = 0; i < 4; i++) begin
            pv[i] = 4'($urandom_range(0, 15));
            pg[i] = $urandom_range(50, 120);
         end
         tx_phase(n);
      end
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      repeat ($urandom_range(10, 100)) @(negedge clk);
      uart_rxd = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         repeat (DIV) @(negedge clk);
      end
      uart_rxd = stop_bit;
      repeat (DIV) @(negedge clk);
      uart_rxd = 1'b1;
      if (stop_bit) rx_model = b[3:0];
      rx_exp.push_back(rx_model);
      $display("rx sent %h stop=%0d", b, stop_bit);
   endtask

   task automatic rx_seq();
      send_rx(8'h35, 1'b1);
      send_rx({4'($urandom_range(0, 15)), rx_model ^ 4'h9}, 1'b0);
      send_rx(8'h0C, 1'b1);
      repeat (20) @(negedge clk);
      uart_rxd = 1'b0;
      repeat (5) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (60) @(negedge clk);
      rx_exp.push_back(rx_model);
      for (int k = 0; k < 8; k++) begin
         logic [7:0] b;
         b = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) begin
            b[3:0] = rx_model ^ 4'h6;
            send_rx(b, 1'b0);
         end else begin
            send_rx(b, 1'b1);
         end
      end
   endtask

   initial begin : tx_mon
      logic       prev;
      logic [7:0] b;
      logic       st, sp, led_all;
      bit         skip;
      byte unsigned e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (prev && uart_txd === 1'b0) begin
            skip      = skip_next;
            skip_next = 1'b0;
            repeat (DIV / 2) @(negedge clk);
            st      = uart_txd;
            led_all = led;
            for (int i = 0; i < 8; i++) begin
               repeat (DIV) @(negedge clk);
               b[i]    = uart_txd;
               led_all = led_all & led;
            end
            repeat (DIV) @(negedge clk);
            sp      = uart_txd;
            led_all = led_all & led;
            if (skip) begin
               $display("tx frame interrupted by reset, ignored");
            end else if (tx_exp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL tx_unexpected_frame actual=%h required=none", b);
            end else begin
               e = tx_exp.pop_front();
               check("tx_byte", {24'd0, b}, {24'd0, e});
               check("tx_start_bit", {31'd0, st}, 32'd0);
               check("tx_stop_bit", {31'd0, sp}, 32'd1);
               check("tx_led_busy", {31'd0, led_all}, 32'd1);
               $display("tx frame %h expected %h", b, e);
            end
         end
         prev = uart_txd;
      end
   end

   initial begin : rx_mon
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (rx_exp.size() > 0) begin
            e = rx_exp.pop_front();
            @(negedge clk);
            check("rx_gpio_nibble", {28'd0, gpio_io[7:4]}, {28'd0, e});
            $display("rx gpio nibble %h expected %h", gpio_io[7:4], e);
         end
      end
   end

   initial begin
      logic [3:0] v;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("reset_txd", {31'd0, uart_txd}, 32'd1);
         check("reset_led", {31'd0, led}, 32'd0);
         check("reset_gpio", {28'd0, gpio_io[7:4]}, 32'd0);
      end
      rst = 1'b1;
      repeat (10) @(negedge clk);

      fork
         tx_seq();
         rx_seq();
      join
      repeat (20) @(negedge clk);

      // Reset in the middle of a frame, then expect a fresh frame from last_in restarting at 0
      v = (model_nib == 4'h3) ? 4'h5 : 4'h3;
      skip_next = 1'b1;
      in_nib    = v;
      repeat (100) @(negedge clk);
      check("pre_reset_led", {31'd0, led}, 32'd1);
      rst = 1'b0;
      #1;
      check("abort_txd", {31'd0, uart_txd}, 32'd1);
      check("abort_led", {31'd0, led}, 32'd0);
      check("abort_gpio", {28'd0, gpio_io[7:4]}, 32'd0);
      repeat (400) @(negedge clk);
      check("held_reset_txd", {31'd0, uart_txd}, 32'd1);
      tx_exp.push_back({4'hA, v});
      model_nib = v;
      rst = 1'b1;
      repeat (1000) @(negedge clk);
      check("post_reset_led", {31'd0, led}, 32'd0);

      check("tx_queue_drained", tx_exp.size(), 32'd0);
      check("rx_queue_drained", rx_exp.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
